make_a_close_to_b_gen: RTL and testbench

Parametrised successor to the fixed 12-bit A-toward-B adjuster. It loads unsigned A and B, then moves A toward B in two phases: a coarse phase and a fine phase. The result always satisfies B − FINE < A ≤ B. Unlike the earlier block, it handles A > B at load by stepping down, never overflows or underflows, and reports direction and step count. It is a standalone Start/Ack RTL exercise block with a one-hot state visible on its outputs.

---
 rtl/make_a_close_to_b_gen_pkg.sv | 22 ++
 rtl/make_a_close_to_b_gen.sv | 140 ++++++++++++++
 tb/tb_make_a_close_to_b_gen.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/make_a_close_to_b_gen_pkg.sv
//==============================================================================
// Module : make_a_close_to_b_gen_pkg
// Brief  : One-hot state encodings and parameter legality check for the
//          A-toward-B adjuster.
// Rev    : 1.0
//==============================================================================
`default_nettype none

package make_a_close_to_b_gen_pkg;

    localparam logic [3:0] c_ST_INI    = 4'b0001;
    localparam logic [3:0] c_ST_COARSE = 4'b0010;
    localparam logic [3:0] c_ST_FINE   = 4'b0100;
    localparam logic [3:0] c_ST_DONE   = 4'b1000;

    function automatic bit params_ok(input int width, input longint coarse, input longint fine);
        return (fine >= 1) && (coarse > fine) && (coarse < (longint'(1) << width));
    endfunction

endpackage

`default_nettype wire

// File: rtl/make_a_close_to_b_gen.sv
//==============================================================================
// Module : make_a_close_to_b_gen
// Brief  : Moves A toward target B in a coarse then a fine phase so that
//          B - FINE < A <= B; Start/Ack handshake, one-hot state outputs.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module make_a_close_to_b_gen
    import make_a_close_to_b_gen_pkg::*;
#(
    parameter int WIDTH  = 12,
    parameter int COARSE = 100,
    parameter int FINE   = 10,
    parameter int CNT_W  = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Ack,
    input  logic [WIDTH-1:0] Ain,
    input  logic [WIDTH-1:0] Bin,
    output logic [WIDTH-1:0] A,
    output logic             Flag,
    output logic             Dn,
    output logic [CNT_W-1:0] Steps,
    output logic             Qi,
    output logic             Qc,
    output logic             Qf,
    output logic             Qd
);

    generate
        if (!params_ok(WIDTH, longint'(COARSE), longint'(FINE))) begin : g_bad_params
            $error("make_a_close_to_b_gen: illegal COARSE/FINE for WIDTH");
        end
    endgenerate

    localparam logic [WIDTH:0]   c_COARSE_X = (WIDTH+1)'(COARSE);
    localparam logic [WIDTH:0]   c_FINE_X   = (WIDTH+1)'(FINE);
    localparam logic [WIDTH-1:0] c_COARSE   = WIDTH'(COARSE);

    logic [3:0]       r_state, w_state_nx;
    logic [WIDTH-1:0] r_a, w_a_nx;
    logic [WIDTH-1:0] r_b, w_b_nx;
    logic             r_flag, w_flag_nx;
    logic             r_dn, w_dn_nx;
    logic [CNT_W-1:0] r_steps, w_steps_nx;

    // Sums carry one extra bit so that A + step can never wrap before the compare.
    logic [WIDTH:0]   w_sum_c, w_sum_f, w_b_x;
    logic [CNT_W-1:0] w_steps_inc;

    assign w_b_x       = {1'b0, r_b};
    assign w_sum_c     = {1'b0, r_a} + c_COARSE_X;
    assign w_sum_f     = {1'b0, r_a} + c_FINE_X;
    assign w_steps_inc = (r_steps == {CNT_W{1'b1}}) ? r_steps : r_steps + CNT_W'(1);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= c_ST_INI;
            r_a     <= '0;
            r_b     <= '0;
            r_flag  <= 1'b0;
            r_dn    <= 1'b0;
            r_steps <= '0;
        end else begin
            r_state <= w_state_nx;
            r_a     <= w_a_nx;
            r_b     <= w_b_nx;
            r_flag  <= w_flag_nx;
            r_dn    <= w_dn_nx;
            r_steps <= w_steps_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_a_nx     = r_a;
        w_b_nx     = r_b;
        w_flag_nx  = r_flag;
        w_dn_nx    = r_dn;
        w_steps_nx = r_steps;
        case (r_state)
            c_ST_INI: begin
                w_a_nx     = Ain;
                w_b_nx     = Bin;
                w_flag_nx  = 1'b0;
                w_steps_nx = '0;
                w_dn_nx    = (Ain > Bin);
                if (Start) w_state_nx = c_ST_COARSE;
            end
            c_ST_COARSE: begin
                if (!r_dn) begin
                    if (w_sum_c <= w_b_x) begin
                        w_a_nx     = w_sum_c[WIDTH-1:0];
                        w_steps_nx = w_steps_inc;
                    end else begin
                        w_flag_nx  = 1'b1;
                        w_state_nx = c_ST_FINE;
                    end
                end else begin
                    if (r_a > r_b) begin
                        w_a_nx     = (r_a >= c_COARSE) ? (r_a - c_COARSE) : '0;
                        w_steps_nx = w_steps_inc;
                    end else begin
                        w_flag_nx  = 1'b1;
                        w_state_nx = c_ST_FINE;
                    end
                end
            end
            c_ST_FINE: begin
                if (w_sum_f <= w_b_x) begin
                    w_a_nx     = w_sum_f[WIDTH-1:0];
                    w_steps_nx = w_steps_inc;
                end else begin
                    w_state_nx = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                if (Ack) w_state_nx = c_ST_INI;
            end
            default: w_state_nx = c_ST_INI;
        endcase
    end

    always_comb begin
        A     = r_a;
        Flag  = r_flag;
        Dn    = r_dn;
        Steps = r_steps;
        Qi    = r_state[0];
        Qc    = r_state[1];
        Qf    = r_state[2];
        Qd    = r_state[3];
    end

endmodule

`default_nettype wire

// File: tb/tb_make_a_close_to_b_gen.sv
//==============================================================================
// Module : tb_make_a_close_to_b_gen
// Brief  : Self-checking bench for make_a_close_to_b_gen.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_make_a_close_to_b_gen;

    logic        Clk = 1'b0;
    logic        Reset, Start, Ack;
    logic [11:0] Ain, Bin;
    logic [11:0] A, A3;
    logic        Flag, Dn, Qi, Qc, Qf, Qd;
    logic        Flag3, Dn3, Qi3, Qc3, Qf3, Qd3;
    logic [7:0]  Steps;
    logic [2:0]  Steps3;

    always #5 Clk = ~Clk;

    make_a_close_to_b_gen dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack), .Ain(Ain), .Bin(Bin),
        .A(A), .Flag(Flag), .Dn(Dn), .Steps(Steps),
        .Qi(Qi), .Qc(Qc), .Qf(Qf), .Qd(Qd)
    );

    // Narrow counter copy, used to observe Steps saturation.
    make_a_close_to_b_gen #(.CNT_W(3)) dut3 (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack), .Ain(Ain), .Bin(Bin),
        .A(A3), .Flag(Flag3), .Dn(Dn3), .Steps(Steps3),
        .Qi(Qi3), .Qc(Qc3), .Qf(Qf3), .Qd(Qd3)
    );

    typedef struct {
        int a;
        bit flag;
        bit dn;
        int steps;
        int steps3;
        int lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic exp_t model(input int ain, input int bin);
        exp_t e;
        int   a = ain;
        int   n = 0;
        e.dn   = (ain > bin);
        e.flag = 1'b1;
        if (!e.dn) begin
            while (a + 100 <= bin) begin a += 100; n++; end
        end else begin
            while (a > bin) begin a = (a >= 100) ? a - 100 : 0; n++; end
        end
        e.lat = n + 1;
        while (a + 10 <= bin) begin a += 10; n++; e.lat++; end
        e.lat++;
        e.a      = a;
        e.steps  = (n > 255) ? 255 : n;
        e.steps3 = (n > 7) ? 7 : n;
        return e;
    endfunction

    task automatic run_op(input int ain, input int bin, input int plan_a,
                          input int plan_steps, input bit ack_noise);
        exp_t e;
        int   lat = 0;
        @(negedge Clk);
        Ain   = 12'(ain);
        Bin   = 12'(bin);
        Start = 1'b1;
        Ack   = ack_noise;
        sb.push_back(model(ain, bin));
        @(posedge Clk);
        #1 Start = 1'b0;
        forever begin
            @(posedge Clk);
            lat++;
            #1;
            n_cmp++;
            if (!$onehot({Qi, Qc, Qf, Qd})) begin
                n_bad++;
                $display("FAIL onehot: got %b want one-hot", {Qi, Qc, Qf, Qd});
            end
            if (Qd === 1'b1 || lat >= 200) break;
        end
        Ack = 1'b0;
        e = sb.pop_front();
        n_cmp++;
        if (Qd !== 1'b1) begin
            n_bad++;
            $display("FAIL done_timeout %0d/%0d: Qd=%b after %0d clocks, want 1", ain, bin, Qd, lat);
        end
        n_cmp++;
        if (lat != e.lat) begin
            n_bad++;
            $display("FAIL latency %0d/%0d: got %0d want %0d", ain, bin, lat, e.lat);
        end
        n_cmp++;
        if (A !== 12'(e.a)) begin
            n_bad++;
            $display("FAIL result_a %0d/%0d: got %0d want %0d", ain, bin, A, e.a);
        end
        n_cmp++;
        if (Flag !== e.flag || Dn !== e.dn) begin
            n_bad++;
            $display("FAIL flag_dn %0d/%0d: got %b%b want %b%b", ain, bin, Flag, Dn, e.flag, e.dn);
        end
        n_cmp++;
        if (Steps !== 8'(e.steps) || Steps3 !== 3'(e.steps3)) begin
            n_bad++;
            $display("FAIL steps %0d/%0d: got %0d/%0d want %0d/%0d", ain, bin, Steps, Steps3, e.steps, e.steps3);
        end
        if (plan_a >= 0) begin
            n_cmp++;
            if (A !== 12'(plan_a) || Steps !== 8'(plan_steps)) begin
                n_bad++;
                $display("FAIL plan %0d/%0d: got A=%0d S=%0d want A=%0d S=%0d", ain, bin, A, Steps, plan_a, plan_steps);
            end
        end
    endtask

    task automatic do_ack();
        @(negedge Clk);
        Ack = 1'b1;
        @(posedge Clk);
        #1 Ack = 1'b0;
        n_cmp++;
        if ({Qi, Qc, Qf, Qd} !== 4'b1000) begin
            n_bad++;
            $display("FAIL ack_return: got QiQcQfQd=%b want 1000", {Qi, Qc, Qf, Qd});
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; Start = 1'b0; Ack = 1'b0; Ain = 12'd7; Bin = 12'd3;
        #12;
        n_cmp++;
        if ({Qi, Qc, Qf, Qd} !== 4'b1000 || A !== 12'd0 || Flag !== 1'b0 || Dn !== 1'b0 || Steps !== 8'd0) begin
            n_bad++;
            $display("FAIL reset: got Q=%b A=%0d F=%b Dn=%b S=%0d want 1000/0/0/0/0", {Qi, Qc, Qf, Qd}, A, Flag, Dn, Steps);
        end
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic test_ini_tracking();
        @(negedge Clk); Ain = 12'd900; Bin = 12'd333;
        @(negedge Clk);
        n_cmp++;
        if (A !== 12'd900 || Dn !== 1'b1 || Qi !== 1'b1) begin
            n_bad++;
            $display("FAIL ini_load_down: got A=%0d Dn=%b Qi=%b want 900/1/1", A, Dn, Qi);
        end
        Ain = 12'd5;
        @(negedge Clk);
        n_cmp++;
        if (A !== 12'd5 || Dn !== 1'b0) begin
            n_bad++;
            $display("FAIL ini_load_up: got A=%0d Dn=%b want 5/0", A, Dn);
        end
    endtask

    task automatic test_main_paths();
        run_op(5, 333, 325, 5, 1'b0);      do_ack();
        run_op(900, 333, 330, 9, 1'b0);    do_ack();
        run_op(50, 50, 50, 0, 1'b0);       do_ack();
        run_op(4000, 4090, 4090, 9, 1'b0); do_ack();
        run_op(60, 5, 0, 1, 1'b0);         do_ack();
        run_op(0, 4095, -1, 0, 1'b0);      do_ack();
        run_op(4095, 0, -1, 0, 1'b0);      do_ack();
        run_op(123, 777, -1, 0, 1'b1);     do_ack();
    endtask

    task automatic test_done_hold();
        logic [11:0] a0;
        logic [7:0]  s0;
        run_op(900, 333, 330, 9, 1'b0);
        a0 = A;
        s0 = Steps;
        @(negedge Clk);
        Start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            n_cmp++;
            if (Qd !== 1'b1 || A !== a0 || Steps !== s0 || Flag !== 1'b1 || Dn !== 1'b1) begin
                n_bad++;
                $display("FAIL done_hold cyc%0d: got Qd=%b A=%0d S=%0d want 1/%0d/%0d", i, Qd, A, Steps, a0, s0);
            end
        end
        Start = 1'b0;
        do_ack();
    endtask

    task automatic test_abort();
        int n = 0;
        @(negedge Clk);
        Ain = 12'd5; Bin = 12'd333; Start = 1'b1;
        @(posedge Clk);
        #1 Start = 1'b0;
        while (Qf !== 1'b1 && n < 50) begin
            @(posedge Clk);
            #1 n++;
        end
        n_cmp++;
        if (Qf !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_reach_fine: got Qf=%b want 1", Qf);
        end
        #2 Reset = 1'b1;
        #1;
        n_cmp++;
        if ({Qi, Qc, Qf, Qd} !== 4'b1000 || A !== 12'd0 || Steps !== 8'd0 || Flag !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_reset: got Q=%b A=%0d S=%0d F=%b want 1000/0/0/0", {Qi, Qc, Qf, Qd}, A, Steps, Flag);
        end
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ini_tracking();
        test_main_paths();
        test_done_hold();
        test_abort();
        run_op(5, 333, 325, 5, 1'b0);
        do_ack();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
